// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the fetch stage and simple_cpu.
//   INSTR_WIDTH / PC_BITS : default instruction width and program-memory address width
//   NOP_WORD / HALT_WORD  : special instruction encodings
//   fetch_state_e         : fetch-stage FSM states
package cpu_pkg;

  localparam int INSTR_WIDTH = 20;
  localparam int PC_BITS     = 5;

  localparam logic [INSTR_WIDTH-1:0] NOP_WORD  = {INSTR_WIDTH{1'b0}};
  localparam logic [INSTR_WIDTH-1:0] HALT_WORD = {INSTR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // True when a word of the default width is the halt encoding.
  function automatic logic is_halt_word(input logic [INSTR_WIDTH-1:0] word);
    return (word == HALT_WORD);
  endfunction

endpackage

// File: rtl/instr_mem.sv
// instr_mem: program memory with one write port and one synchronous read port.
//   clk   : clock
//   we    : write strobe; waddr/wdata written on the rising edge
//   re    : read enable; when low the read register holds its last value
//   raddr : read address
//   rdata : registered read data (valid the cycle after a read-enabled edge)
// The array and the read register are deliberately not reset.
module instr_mem #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [PC_BITS-1:0]     waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic                   re,
  input  logic [PC_BITS-1:0]     raddr,
  output logic [INSTR_WIDTH-1:0] rdata
);

  logic [INSTR_WIDTH-1:0] mem_r [2**PC_BITS];
  logic [INSTR_WIDTH-1:0] rdata_r;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Synchronous read port; holding on re=0 is what freezes the in-flight word during a stall.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding simple_cpu.
//   clk, rst          : clock, synchronous active-low reset
//   start             : begin execution at address 0 (IDLE/HALT only)
//   stall             : freeze fetch PC, read stage and outputs
//   load_en/addr/data : program-memory write (IDLE/HALT only)
//   jump_en/jump_addr : redirect fetch (RUN, not stalled)
//   instruction       : fetched word, NOP when instr_valid=0
//   instr_valid       : instruction is a real fetched word
//   pc                : address of the displayed word
//   halted / busy     : state is HALT / RUN
// Pipeline: fetch PC -> synchronous memory read (tagged with rd_valid/rd_pc/squash) -> output registers.
module instr_fetch #(
  parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter int PC_BITS     = cpu_pkg::PC_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   jump_en,
  input  logic [PC_BITS-1:0]     jump_addr,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   halted,
  output logic                   busy
);

  import cpu_pkg::*;

  localparam logic [INSTR_WIDTH-1:0] NOP_W  = {INSTR_WIDTH{1'b0}};
  localparam logic [INSTR_WIDTH-1:0] HALT_W = {INSTR_WIDTH{1'b1}};

  fetch_state_e           state_r;
  logic [PC_BITS-1:0]     fetch_pc_r;
  logic                   rd_valid_r;   // read register holds a word fetched in RUN
  logic [PC_BITS-1:0]     rd_pc_r;      // address of the word in the read register
  logic                   squash_r;     // that word was fetched in the cycle a jump was taken
  logic [INSTR_WIDTH-1:0] instruction_r;
  logic                   instr_valid_r;
  logic [PC_BITS-1:0]     pc_r;

  logic                   rd_en_s;
  logic                   we_s;
  logic [INSTR_WIDTH-1:0] rd_data_s;
  logic                   live_s;
  logic                   word_ok_s;
  logic                   hit_halt_s;

  instr_mem #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .PC_BITS     (PC_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (we_s),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (rd_en_s),
    .raddr (fetch_pc_r),
    .rdata (rd_data_s)
  );

  // Memory strobes and classification of the word sitting in the read register.
  always_comb begin
    rd_en_s    = 1'b0;
    we_s       = 1'b0;
    live_s     = 1'b0;
    word_ok_s  = 1'b0;
    hit_halt_s = 1'b0;
    if (state_r == ST_RUN) begin
      rd_en_s = ~stall;
    end else begin
      we_s = load_en;
    end
    live_s = (state_r == ST_RUN) && rd_valid_r && !squash_r;
    if (live_s) begin
      hit_halt_s = (rd_data_s == HALT_W);
      word_ok_s  = (rd_data_s != HALT_W);
    end else begin
      hit_halt_s = 1'b0;
      word_ok_s  = 1'b0;
    end
  end

  // FSM, fetch PC, read-stage tags and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      fetch_pc_r    <= {PC_BITS{1'b0}};
      rd_valid_r    <= 1'b0;
      rd_pc_r       <= {PC_BITS{1'b0}};
      squash_r      <= 1'b0;
      instruction_r <= NOP_W;
      instr_valid_r <= 1'b0;
      pc_r          <= {PC_BITS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_HALT: begin
          instruction_r <= NOP_W;
          instr_valid_r <= 1'b0;
          rd_valid_r    <= 1'b0;
          squash_r      <= 1'b0;
          if (start) begin
            state_r    <= ST_RUN;
            fetch_pc_r <= {PC_BITS{1'b0}};
          end
        end
        ST_RUN: begin
          if (!stall) begin
            // The word read on this edge is the sequential one; a jump here marks it for squashing.
            rd_valid_r <= 1'b1;
            rd_pc_r    <= fetch_pc_r;
            squash_r   <= jump_en;
            fetch_pc_r <= jump_en ? jump_addr : fetch_pc_r + PC_BITS'(1);
            if (word_ok_s) begin
              instruction_r <= rd_data_s;
              instr_valid_r <= 1'b1;
              pc_r          <= rd_pc_r;
            end else begin
              instruction_r <= NOP_W;
              instr_valid_r <= 1'b0;
            end
            if (hit_halt_s) begin
              state_r <= ST_HALT;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign instruction = instruction_r;
  assign instr_valid = instr_valid_r;
  assign pc          = pc_r;
  assign halted      = (state_r == ST_HALT);
  assign busy        = (state_r == ST_RUN);

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [19:0] load_data;
  logic        jump_en;
  logic [4:0]  jump_addr;
  logic [19:0] instruction;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        halted;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  instr_fetch #(.INSTR_WIDTH(20), .PC_BITS(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stall       (stall),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [19:0] ei, input logic ev, input logic [4:0] ep);
    chk({tag, ".instr"}, {12'd0, instruction}, {12'd0, ei});
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, ev});
    if (ev) chk({tag, ".pc"}, {27'd0, pc}, {27'd0, ep});
  endtask

  task automatic chk_state(input string tag, input logic eh, input logic eb);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, eh});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
  endtask

  task automatic load(input logic [4:0] a, input logic [19:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // start edge, then the address-0 read edge; the next tick shows mem[0]
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_state("start.busy", 1'b0, 1'b1);
    tick();
    chk_word("start.bubble", 20'h00000, 1'b0, 5'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stall = 1'b0; load_en = 1'b0;
    load_addr = 5'd0; load_data = 20'd0; jump_en = 1'b0; jump_addr = 5'd0;

    // Reset state
    tick();
    chk_word("rst", 20'h00000, 1'b0, 5'd0);
    chk("rst.pc", {27'd0, pc}, 32'd0);
    chk_state("rst", 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_state("idle", 1'b0, 1'b0);

    // Basic run to halt
    load(5'd0, 20'h00011);
    load(5'd1, 20'h00022);
    load(5'd2, 20'h00033);
    load(5'd3, 20'hFFFFF);
    do_start();
    tick(); chk_word("run0", 20'h00011, 1'b1, 5'd0);
    tick(); chk_word("run1", 20'h00022, 1'b1, 5'd1);
    tick(); chk_word("run2", 20'h00033, 1'b1, 5'd2);
    tick(); chk_word("halt", 20'h00000, 1'b0, 5'd0);
    chk_state("halt", 1'b1, 1'b0);
    tick(); chk_state("halt.hold", 1'b1, 1'b0);

    // Stall for 3 cycles while 0x00022 is displayed
    do_start();
    tick(); chk_word("st0", 20'h00011, 1'b1, 5'd0);
    tick(); chk_word("st1", 20'h00022, 1'b1, 5'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_word("stall.hold", 20'h00022, 1'b1, 5'd1);
    end
    stall = 1'b0;
    tick(); chk_word("st2", 20'h00033, 1'b1, 5'd2);
    tick(); chk_state("st.halt", 1'b1, 1'b0);

    // Jump to 10 in the cycle mem[0] is read out
    load(5'd0, 20'h00001);
    load(5'd1, 20'h00002);
    load(5'd2, 20'h00003);
    load(5'd10, 20'h000AA);
    load(5'd11, 20'hFFFFF);
    do_start();
    jump_en = 1'b1; jump_addr = 5'd10;
    tick(); chk_word("j.mem0", 20'h00001, 1'b1, 5'd0);
    jump_en = 1'b0;
    tick(); chk_word("j.squash", 20'h00000, 1'b0, 5'd0);
    tick(); chk_word("j.target", 20'h000AA, 1'b1, 5'd10);
    tick(); chk_state("j.halt", 1'b1, 1'b0);

    // Wrap across all 32 entries; load_en in RUN must be ignored
    for (int i = 0; i < 32; i++) load(5'(i), 20'h00100 + 20'(i));
    do_start();
    for (int i = 0; i < 32; i++) begin
      if (i == 2) begin
        load_en = 1'b1; load_addr = 5'd4; load_data = 20'hFFFFF;
      end else begin
        load_en = 1'b0;
      end
      tick();
      chk_word("wrap.seq", 20'h00100 + 20'(i), 1'b1, 5'(i));
    end
    load_en = 1'b0;
    tick(); chk_word("wrap.w0", 20'h00100, 1'b1, 5'd0);
    chk_state("wrap.run", 1'b0, 1'b1);

    // Reset mid-run, then replay
    rst = 1'b0;
    tick();
    chk_word("midrst", 20'h00000, 1'b0, 5'd0);
    chk("midrst.pc", {27'd0, pc}, 32'd0);
    chk_state("midrst", 1'b0, 1'b0);
    rst = 1'b1;
    do_start();
    tick(); chk_word("replay0", 20'h00100, 1'b1, 5'd0);
    tick(); chk_word("replay1", 20'h00101, 1'b1, 5'd1);

    // Simultaneous start and load to address 0 from IDLE
    rst = 1'b0;
    tick();
    rst = 1'b1;
    load_en = 1'b1; load_addr = 5'd0; load_data = 20'h00055;
    do_start();
    load_en = 1'b0;
    tick(); chk_word("ldstart0", 20'h00055, 1'b1, 5'd0);
    tick(); chk_word("ldstart1", 20'h00101, 1'b1, 5'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
